// File: rtl/spi_slave_burst_pkg.sv
// Shared types for the burst SPI slave: FSM states, command codes and payload width helper.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_HDR,
    WR_BURST,
    RD_WAIT,
    RD_SHIFT,
    DRAIN
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Header payload must carry either an address or a data word.
  function automatic int payload_width(input int addr_w, input int data_w);
    return (addr_w > data_w) ? addr_w : data_w;
  endfunction

endpackage

// File: rtl/spi_slave_burst_tx_shifter.sv
// MISO serialiser: parallel load puts the first bit on MISO at once, then one bit per clk.
// done is high during the last bit's cycle so the controller can act on that same edge.
module spi_tx_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  miso,
  output logic                  done
);

  localparam int NW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sreg;
  logic [NW-1:0]         cnt;
  logic                  active;

  assign done = active && (cnt == NW'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sreg   <= '0;
      cnt    <= '0;
      active <= 1'b0;
      miso   <= 1'b0;
    end else if (load) begin
      sreg   <= data;
      cnt    <= '0;
      active <= 1'b1;
      miso   <= (LSB_FIRST != 0) ? data[0] : data[DATA_WIDTH-1];
    end else if (active) begin
      if (done) begin
        cnt    <= '0;
        active <= 1'b0;
        miso   <= 1'b0;
      end else begin
        cnt <= cnt + NW'(1);
        // miso takes the bit that becomes the head of sreg after this shift
        if (LSB_FIRST != 0) begin
          sreg <= sreg >> 1;
          miso <= sreg[1];
        end else begin
          sreg <= sreg << 1;
          miso <= sreg[DATA_WIDTH-2];
        end
      end
    end
  end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave front-end: deserialises {cmd, payload} frames, supports burst write/read under one SS_n,
// serialises RAM read words onto MISO and flags a read-data command with no pending read address.
module spi_slave_burst
  import spi_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 0,
  parameter int BURST_EN   = 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                SS_n,
  input  logic                                                MOSI,
  input  logic                                                tx_valid,
  input  logic [DATA_WIDTH-1:0]                               tx_data,
  output logic                                                rx_valid,
  output logic [payload_width(ADDR_WIDTH, DATA_WIDTH)+1:0]    rx_data,
  output logic                                                MISO,
  output logic                                                frame_err
);

  localparam int W  = payload_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(W + 2);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [1:0]            cmd;
  logic [W-1:0]          pay;
  logic [W-1:0]          pay_nxt;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  rd_flag;
  logic                  ld;
  logic                  done;

  always_comb begin
    pay_nxt  = '0;
    word_nxt = '0;
    if (LSB_FIRST != 0) begin
      pay_nxt  = {MOSI, pay[W-1:1]};
      word_nxt = {MOSI, word[DATA_WIDTH-1:1]};
    end else begin
      pay_nxt  = {pay[W-2:0], MOSI};
      word_nxt = {word[DATA_WIDTH-2:0], MOSI};
    end
  end

  assign ld = (state == RD_WAIT) && !SS_n && tx_valid;

  spi_tx_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .clear(SS_n),
    .data (tx_data),
    .miso (MISO),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd       <= '0;
      pay       <= '0;
      word      <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      rd_flag   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      // Deselect abandons any partial frame; rd_flag survives for the next frame.
      if (SS_n) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= RX_HDR;
            cnt   <= '0;
          end
          RX_HDR: begin
            if (cnt < CW'(2)) cmd <= {cmd[0], MOSI};
            else              pay <= pay_nxt;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(W + 1)) begin
              cnt <= '0;
              case (cmd)
                CMD_WR_ADDR: begin
                  rx_valid <= 1'b1;
                  rx_data  <= {cmd, pay_nxt};
                  state    <= DRAIN;
                end
                CMD_WR_DATA: begin
                  rx_valid <= 1'b1;
                  rx_data  <= {cmd, pay_nxt};
                  state    <= (BURST_EN != 0) ? WR_BURST : DRAIN;
                end
                CMD_RD_ADDR: begin
                  rx_valid <= 1'b1;
                  rx_data  <= {cmd, pay_nxt};
                  rd_flag  <= 1'b1;
                  state    <= DRAIN;
                end
                default: begin
                  if (rd_flag) begin
                    rx_valid <= 1'b1;
                    rx_data  <= {cmd, pay_nxt};
                    rd_flag  <= 1'b0;
                    state    <= RD_WAIT;
                  end else begin
                    frame_err <= 1'b1;
                    state     <= DRAIN;
                  end
                end
              endcase
            end
          end
          WR_BURST: begin
            word <= word_nxt;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(DATA_WIDTH - 1)) begin
              cnt      <= '0;
              rx_valid <= 1'b1;
              rx_data  <= {CMD_WR_DATA, W'(word_nxt)};
            end
          end
          RD_WAIT: begin
            if (tx_valid) state <= RD_SHIFT;
          end
          RD_SHIFT: begin
            if (done) begin
              if (BURST_EN != 0) begin
                // Request the next read word from the RAM controller.
                rx_valid <= 1'b1;
                rx_data  <= {CMD_RD_DATA, {W{1'b0}}};
                state    <= RD_WAIT;
              end else begin
                state <= DRAIN;
              end
            end
          end
          DRAIN: state <= DRAIN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench: default instance (MSB first, 8/8) and a wide LSB-first instance (10/16).
module tb_spi_slave_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ss_a = 1'b1, mosi_a = 1'b0, txv_a = 1'b0;
  logic [7:0]  txd_a = '0;
  logic        rxv_a, miso_a, ferr_a;
  logic [9:0]  rxd_a;

  logic        ss_b = 1'b1, mosi_b = 1'b0, txv_b = 1'b0;
  logic [15:0] txd_b = '0;
  logic        rxv_b, miso_b, ferr_b;
  logic [17:0] rxd_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_slave_burst u_a (
    .clk(clk), .rst(rst), .SS_n(ss_a), .MOSI(mosi_a), .tx_valid(txv_a), .tx_data(txd_a),
    .rx_valid(rxv_a), .rx_data(rxd_a), .MISO(miso_a), .frame_err(ferr_a)
  );

  spi_slave_burst #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .LSB_FIRST(1), .BURST_EN(1)) u_b (
    .clk(clk), .rst(rst), .SS_n(ss_b), .MOSI(mosi_b), .tx_valid(txv_b), .tx_data(txd_b),
    .rx_valid(rxv_b), .rx_data(rxd_b), .MISO(miso_b), .frame_err(ferr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifts v[n-1:0] out MSB first; counts strobes seen before the final bit.
  task automatic send_a(input logic [17:0] v, input int n, output int strobes);
    strobes = 0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi_a = v[i];
      tick();
      if (i > 0 && (rxv_a || ferr_a)) strobes++;
    end
  endtask

  task automatic send_b(input logic [17:0] v, input int n, output int strobes);
    strobes = 0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi_b = v[i];
      tick();
      if (i > 0 && (rxv_b || ferr_b)) strobes++;
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15 - i];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({rxv_a, ferr_a, miso_a, rxd_a} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_a: got rxv=%b ferr=%b miso=%b rxd=%h expected all 0", rxv_a, ferr_a, miso_a, rxd_a);
    end
    vectors++;
    if ({rxv_b, ferr_b, miso_b, rxd_b} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_b: got rxv=%b ferr=%b miso=%b rxd=%h expected all 0", rxv_b, ferr_b, miso_b, rxd_b);
    end
  endtask

  task automatic test_write_addr();
    int s;
    int extra;
    ss_a = 1'b0;
    tick();
    send_a({8'h0, 2'b00, 8'h3C}, 10, s);
    vectors++;
    if (rxv_a !== 1'b1 || rxd_a !== 10'h03C || s != 0) begin
      miscompares++;
      $display("FAIL wr_addr: got rxv=%b rxd=%h early=%0d expected rxv=1 rxd=03c early=0", rxv_a, rxd_a, s);
    end
    send_a(18'h2D5A7, 18, s);
    extra = s + ((rxv_a || ferr_a) ? 1 : 0);
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL drain_quiet: got %0d strobes expected 0", extra);
    end
    ss_a = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int s;
    logic [7:0] exp_bits;
    ss_a = 1'b0;
    tick();
    send_a({8'h0, 2'b10, 8'hA5}, 10, s);
    vectors++;
    if (rxv_a !== 1'b1 || rxd_a !== 10'h2A5) begin
      miscompares++;
      $display("FAIL rd_addr: got rxv=%b rxd=%h expected rxv=1 rxd=2a5", rxv_a, rxd_a);
    end
    ss_a = 1'b1;
    tick();
    tick();
    ss_a = 1'b0;
    tick();
    send_a({8'h0, 2'b11, 8'h00}, 10, s);
    vectors++;
    if (rxv_a !== 1'b1 || rxd_a !== 10'h300 || ferr_a !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_data: got rxv=%b rxd=%h ferr=%b expected rxv=1 rxd=300 ferr=0", rxv_a, rxd_a, ferr_a);
    end
    tick();
    vectors++;
    if (miso_a !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_wait_miso: got %b expected 0", miso_a);
    end
    txv_a = 1'b1;
    txd_a = 8'hC3;
    tick();
    txv_a = 1'b0;
    exp_bits = 8'b1100_0011;
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (miso_a !== exp_bits[7 - k]) begin
        miscompares++;
        $display("FAIL miso_c3_bit%0d: got %b expected %b", k, miso_a, exp_bits[7 - k]);
      end
      if (k < 7) tick();
    end
    tick();
    vectors++;
    if (miso_a !== 1'b0 || rxv_a !== 1'b1 || rxd_a !== 10'h300) begin
      miscompares++;
      $display("FAIL rd_next_req: got miso=%b rxv=%b rxd=%h expected miso=0 rxv=1 rxd=300", miso_a, rxv_a, rxd_a);
    end
    ss_a = 1'b1;
    tick();
  endtask

  task automatic test_frame_err();
    int s;
    ss_a = 1'b0;
    tick();
    send_a({8'h0, 2'b11, 8'h5A}, 10, s);
    vectors++;
    if (ferr_a !== 1'b1 || rxv_a !== 1'b0 || miso_a !== 1'b0) begin
      miscompares++;
      $display("FAIL ferr_pulse: got ferr=%b rxv=%b miso=%b expected ferr=1 rxv=0 miso=0", ferr_a, rxv_a, miso_a);
    end
    tick();
    vectors++;
    if (ferr_a !== 1'b0 || rxv_a !== 1'b0 || miso_a !== 1'b0) begin
      miscompares++;
      $display("FAIL ferr_one_cycle: got ferr=%b rxv=%b miso=%b expected 0 0 0", ferr_a, rxv_a, miso_a);
    end
    ss_a = 1'b1;
    tick();
  endtask

  task automatic test_burst_write();
    int s;
    ss_a = 1'b0;
    tick();
    send_a({8'h0, 2'b01, 8'h11}, 10, s);
    vectors++;
    if (rxv_a !== 1'b1 || rxd_a !== 10'h111) begin
      miscompares++;
      $display("FAIL burst_w0: got rxv=%b rxd=%h expected rxv=1 rxd=111", rxv_a, rxd_a);
    end
    send_a({10'h0, 8'h22}, 8, s);
    vectors++;
    if (rxv_a !== 1'b1 || rxd_a !== 10'h122 || s != 0) begin
      miscompares++;
      $display("FAIL burst_w1: got rxv=%b rxd=%h early=%0d expected rxv=1 rxd=122 early=0", rxv_a, rxd_a, s);
    end
    send_a({10'h0, 8'h33}, 8, s);
    vectors++;
    if (rxv_a !== 1'b1 || rxd_a !== 10'h133 || s != 0) begin
      miscompares++;
      $display("FAIL burst_w2: got rxv=%b rxd=%h early=%0d expected rxv=1 rxd=133 early=0", rxv_a, rxd_a, s);
    end
    ss_a = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    int s;
    int seen;
    ss_a = 1'b0;
    tick();
    send_a({13'h0, 5'b00101}, 5, s);
    seen = s + (rxv_a ? 1 : 0);
    ss_a = 1'b1;
    tick();
    seen += rxv_a ? 1 : 0;
    tick();
    seen += rxv_a ? 1 : 0;
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: got %0d strobes expected 0", seen);
    end
    ss_a = 1'b0;
    tick();
    send_a({8'h0, 2'b00, 8'h01}, 10, s);
    vectors++;
    if (rxv_a !== 1'b1 || rxd_a !== 10'h001) begin
      miscompares++;
      $display("FAIL after_abort: got rxv=%b rxd=%h expected rxv=1 rxd=001", rxv_a, rxd_a);
    end
    ss_a = 1'b1;
    tick();
  endtask

  task automatic test_lsb_wide();
    int s;
    logic [15:0] d;
    ss_b = 1'b0;
    tick();
    send_b({2'b10, rev16(16'h02B5)}, 18, s);
    vectors++;
    if (rxv_b !== 1'b1 || rxd_b !== 18'h202B5) begin
      miscompares++;
      $display("FAIL lsb_rd_addr: got rxv=%b rxd=%h expected rxv=1 rxd=202b5", rxv_b, rxd_b);
    end
    ss_b = 1'b1;
    tick();
    ss_b = 1'b0;
    tick();
    send_b({2'b11, 16'h0000}, 18, s);
    vectors++;
    if (rxv_b !== 1'b1 || rxd_b !== 18'h30000) begin
      miscompares++;
      $display("FAIL lsb_rd_data: got rxv=%b rxd=%h expected rxv=1 rxd=30000", rxv_b, rxd_b);
    end
    d = 16'h8001;
    txv_b = 1'b1;
    txd_b = d;
    tick();
    txv_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (miso_b !== d[k]) begin
        miscompares++;
        $display("FAIL lsb_miso_bit%0d: got %b expected %b", k, miso_b, d[k]);
      end
      if (k < 15) tick();
    end
    tick();
    vectors++;
    if (miso_b !== 1'b0 || rxv_b !== 1'b1 || rxd_b !== 18'h30000) begin
      miscompares++;
      $display("FAIL lsb_next_req: got miso=%b rxv=%b rxd=%h expected miso=0 rxv=1 rxd=30000", miso_b, rxv_b, rxd_b);
    end
    txv_b = 1'b1;
    txd_b = 16'hFFFF;
    tick();
    txv_b = 1'b0;
    tick();
    tick();
    vectors++;
    if (miso_b !== 1'b1) begin
      miscompares++;
      $display("FAIL lsb_shift_ffff: got %b expected 1", miso_b);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (miso_b !== 1'b0 || rxv_b !== 1'b0 || ferr_b !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_shift: got miso=%b rxv=%b ferr=%b expected 0 0 0", miso_b, rxv_b, ferr_b);
    end
    // SS_n still low: a fresh frame must start from IDLE with rd_flag cleared.
    tick();
    send_b({2'b11, 16'h0000}, 18, s);
    vectors++;
    if (ferr_b !== 1'b1 || rxv_b !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_clears_rdflag: got ferr=%b rxv=%b expected ferr=1 rxv=0", ferr_b, rxv_b);
    end
    ss_b = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_read();
    test_frame_err();
    test_burst_write();
    test_abort();
    test_lsb_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
Parametrised SPI slave front-end that sits between an SPI master and a single-port RAM controller. It deserialises MOSI frames of {2-bit command, payload} and presents them on rx_data with a one-cycle rx_valid strobe. It serialises RAM read data onto MISO. Compared with the single-word slave, it adds independent address/data widths, selectable payload bit order, burst write/read while SS_n stays low, and a frame-error strobe for an unpaired read-data command.

Parameters:
ADDR_WIDTH, 8, RAM address bits
DATA_WIDTH, 8, RAM data bits
LSB_FIRST, 0, 1 = payload and MISO data sent LSB first; command bits are always first and MSB first
BURST_EN, 1, 1 = burst write/read continue while SS_n stays low

Ports:
clk  in  1  clock; SPI bit clock, all sampling on posedge
rst  in  1  synchronous, active-high reset
SS_n  in  1  slave select, active low
MOSI  in  1  serial data from master
tx_valid  in  1  tx_data valid from RAM controller
tx_data  in  DATA_WIDTH  read word from RAM controller
rx_valid  out  1  one-cycle strobe, rx_data valid
rx_data  out  W+2  {cmd[1:0], payload[W-1:0]}, where W = max(ADDR_WIDTH, DATA_WIDTH)
MISO  out  1  serial data to master
frame_err  out  1  one-cycle strobe: read-data command with no pending read address

Behaviour:
- Reset: rst is sampled on the clk posedge only. It sets state IDLE, all counters to zero, rx_valid=0, rx_data=0, MISO=0, frame_err=0, rd_flag=0. All outputs are registered.
- Commands: 00 write address, 01 write data, 10 read address, 11 read data.
- States: IDLE, RX_HDR, WR_BURST, RD_WAIT, RD_SHIFT, DRAIN.
- IDLE: if SS_n=0, go to RX_HDR. No MOSI bit is sampled on this edge.
- RX_HDR: sample one MOSI bit per edge, W+2 bits total.
  - cmd is bits 0-1, MSB first.
  - Payload is assembled per LSB_FIRST.
  - rx_data and rx_valid are registered on the cycle after the last sampled bit.
- Decode at header completion:
  - 00: rx_valid=1, go to DRAIN.
  - 01: rx_valid=1. Go to WR_BURST if BURST_EN, else DRAIN.
  - 10: rx_valid=1, set rd_flag, go to DRAIN.
  - 11 with rd_flag=1: rx_valid=1, clear rd_flag, go to RD_WAIT.
  - 11 with rd_flag=0: rx_valid=0, frame_err=1 for one cycle, go to DRAIN.
- WR_BURST: collect DATA_WIDTH bits, then pulse rx_valid with rx_data = {2'b01, zero-extended word}. Repeat indefinitely.
- RD_WAIT: wait for tx_valid=1.
  - On that edge, load the shift register and drive MISO = first data bit. Go to RD_SHIFT.
  - tx_valid in any other state is ignored.
- RD_SHIFT:
  - MISO presents bit k in cycle k after load, k = 0..DATA_WIDTH-1; bit order per LSB_FIRST.
  - After the last bit, if BURST_EN and SS_n=0: pulse rx_valid with {2'b11, 0} to request the next word, go to RD_WAIT. Otherwise go to DRAIN.
- MISO is 0 in every state except RD_SHIFT.
- DRAIN: ignore MOSI until SS_n=1.
- SS_n=1 in any non-IDLE state:
  - Next state is IDLE; counters clear; MISO goes to 0 next cycle.
  - A partial header or burst word is discarded with no rx_valid.
  - A strobe already registered from a completed frame still issues.
  - rd_flag is preserved across frames.
- SS_n low on the edge of the last bit completes the frame even if SS_n rises on the next edge.
- rst mid-frame aborts immediately to reset values; rd_flag is cleared.
- rx_valid and frame_err are never high for more than one consecutive cycle per event. Each is never high together with the other.

Decomposition:
- Shared package spi_slave_pkg contains:
  - state enum
  - command localparams CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA
  - width helper function for W
- One sub-module, spi_tx_shifter: parallel load on tx_valid, DATA_WIDTH shift with LSB_FIRST, done pulse, MISO register.

Test Plan:
1. Reset, then SS_n low, header 00 + payload 0x3C (defaults) -> one cycle after the 10th bit, rx_valid=1 with rx_data=10'h03C; then DRAIN, no further strobes.
2. Header 10 addr 0xA5, SS_n high, then header 11 -> rx_valid with 10'h2A5, then rx_valid with 10'h300. tx_valid with tx_data=0xC3 -> MISO 1,1,0,0,0,0,1,1 on the next 8 cycles, then 0.
3. Header 11 with no prior 10 -> frame_err for exactly one cycle, rx_valid stays 0, MISO stays 0.
4. Burst write: header 01 data 0x11, SS_n held low, then 0x22 and 0x33 -> three rx_valid strobes with 0x111, 0x122, 0x133, each 8 cycles apart.
5. SS_n raised after 5 header bits -> no rx_valid; next full frame 00 0x01 decodes correctly to 0x001.
6. LSB_FIRST=1, DATA_WIDTH=16, ADDR_WIDTH=10 -> rx_data is 18 bits; read of tx_data=0x8001 -> MISO 1, then 14 zeros, then 1. rst asserted during RD_SHIFT -> MISO=0 and state IDLE next cycle.
